prv664_int_scoreboard: RTL and testbench

Integer-register scoreboard for the prv664 pipeline; the responder side of `scoreboard_update_interface`. It records which in-flight instruction (itag) owns each integer destination register, and exports per-register busy and owner flags back to dispatch. Ownership is released on writeback when the tag matches, and all of it is cleared on pipeline flush. It sits between dispatch (set side) and the commit/writeback path (clear side).

---
 rtl/prv664_int_scoreboard_pkg.sv | 25 ++
 rtl/prv664_sb_entry.sv | 54 +++++
 rtl/prv664_int_scoreboard.sv | 79 +++++++
 tb/tb_prv664_int_scoreboard.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/prv664_int_scoreboard_pkg.sv
// Shared prv664 scoreboard types and sizes.
// Reused by both the integer and floating-point scoreboards.
package prv664_int_scoreboard_pkg;

    localparam int unsigned NREG   = 32;
    localparam int unsigned ITAG_W = 8;
    localparam int unsigned NWB    = 2;
    localparam int unsigned RIDX_W = 5;
    localparam int unsigned CNT_W  = 6;

    typedef struct packed {
        logic              busy;
        logic [ITAG_W-1:0] itag;
    } sb_entry_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [NREG-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prv664_sb_entry.sv
// One scoreboard register entry: busy bit and owner tag.
// Priority within the entry: reset > flush > set > tag-matched release.
module prv664_sb_entry
    import prv664_int_scoreboard_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       i_flush,
    input  logic                       i_set,
    input  logic [ITAG_W-1:0]          i_set_itag,
    input  logic [NWB-1:0]             i_rel,
    input  logic [NWB-1:0][ITAG_W-1:0] i_rel_itag,
    output sb_entry_t                  o_next_c,
    output sb_entry_t                  o_entry
);

    sb_entry_t r_entry;
    sb_entry_t w_next;
    logic      w_rel_hit;

    // Release only when the writer still owns the register
    always_comb begin
        w_rel_hit = 1'b0;
        for (int k = 0; k < int'(NWB); k++) begin
            if (i_rel[k] && (i_rel_itag[k] == r_entry.itag)) begin
                w_rel_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_entry;
        if (i_flush) begin
            w_next = '0;
        end else if (i_set) begin
            w_next.busy = 1'b1;
            w_next.itag = i_set_itag;
        end else if (r_entry.busy && w_rel_hit) begin
            w_next.busy = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            r_entry <= '0;
        end else begin
            r_entry <= w_next;
        end
    end

    assign o_next_c = w_next;
    assign o_entry  = r_entry;

endmodule

// File: rtl/prv664_int_scoreboard.sv
// Integer-register scoreboard: tracks owning itag per destination register,
// set from dispatch, released on tag-matched writeback, cleared on flush.
module prv664_int_scoreboard
    import prv664_int_scoreboard_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       flush_i,
    input  logic                       upd0_write,
    input  logic [RIDX_W-1:0]          upd0_rdindex,
    input  logic [ITAG_W-1:0]          upd0_itag,
    input  logic                       upd1_write,
    input  logic [RIDX_W-1:0]          upd1_rdindex,
    input  logic [ITAG_W-1:0]          upd1_itag,
    input  logic [NWB-1:0]             wb_valid,
    input  logic [NWB-1:0][RIDX_W-1:0] wb_rdindex,
    input  logic [NWB-1:0][ITAG_W-1:0] wb_itag,
    output logic [NREG-1:0]            busy_flag,
    output logic [NREG-1:0][ITAG_W-1:0] id_flag,
    output logic [CNT_W-1:0]           busy_cnt
);

    logic [NREG-1:0]  w_busy;
    logic [NREG-1:0]  w_next_busy;
    logic [CNT_W-1:0] r_busy_cnt;

    // Register 0 is hardwired free
    assign w_busy[0]      = 1'b0;
    assign w_next_busy[0] = 1'b0;
    assign id_flag[0]     = '0;

    for (genvar g = 1; g < int'(NREG); g++) begin : g_ent
        logic                  w_set0;
        logic                  w_set1;
        logic [NWB-1:0]        w_rel;
        sb_entry_t             w_next;
        sb_entry_t             w_entry;

        assign w_set0 = upd0_write && (upd0_rdindex == RIDX_W'(g));
        assign w_set1 = upd1_write && (upd1_rdindex == RIDX_W'(g));

        always_comb begin
            w_rel = '0;
            for (int k = 0; k < int'(NWB); k++) begin
                w_rel[k] = wb_valid[k] && (wb_rdindex[k] == RIDX_W'(g));
            end
        end

        // Younger port 1 wins the tag when both claim the same register
        prv664_sb_entry u_entry (
            .clk_i      (clk_i),
            .arst_i     (arst_i),
            .i_flush    (flush_i),
            .i_set      (w_set0 || w_set1),
            .i_set_itag (w_set1 ? upd1_itag : upd0_itag),
            .i_rel      (w_rel),
            .i_rel_itag (wb_itag),
            .o_next_c   (w_next),
            .o_entry    (w_entry)
        );

        assign w_busy[g]      = w_entry.busy;
        assign w_next_busy[g] = w_next.busy;
        assign id_flag[g]     = w_entry.itag;
    end

    // Count is registered alongside the busy vector it describes
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            r_busy_cnt <= '0;
        end else begin
            r_busy_cnt <= popcount(w_next_busy);
        end
    end

    assign busy_flag = w_busy;
    assign busy_cnt  = r_busy_cnt;

endmodule

// File: tb/tb_prv664_int_scoreboard.sv
// Directed and randomized self-checking bench for prv664_int_scoreboard.
module tb_prv664_int_scoreboard;

    logic             clk_i = 1'b0;
    logic             arst_i;
    logic             flush_i;
    logic             upd0_write, upd1_write;
    logic [4:0]       upd0_rdindex, upd1_rdindex;
    logic [7:0]       upd0_itag, upd1_itag;
    logic [1:0]       wb_valid;
    logic [1:0][4:0]  wb_rdindex;
    logic [1:0][7:0]  wb_itag;
    logic [31:0]      busy_flag;
    logic [31:0][7:0] id_flag;
    logic [5:0]       busy_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]      m_busy;
    logic [31:0][7:0] m_id;

    prv664_int_scoreboard dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .flush_i      (flush_i),
        .upd0_write   (upd0_write),
        .upd0_rdindex (upd0_rdindex),
        .upd0_itag    (upd0_itag),
        .upd1_write   (upd1_write),
        .upd1_rdindex (upd1_rdindex),
        .upd1_itag    (upd1_itag),
        .wb_valid     (wb_valid),
        .wb_rdindex   (wb_rdindex),
        .wb_itag      (wb_itag),
        .busy_flag    (busy_flag),
        .id_flag      (id_flag),
        .busy_cnt     (busy_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        arst_i = 1'b0; flush_i = 1'b0;
        upd0_write = 1'b0; upd0_rdindex = '0; upd0_itag = '0;
        upd1_write = 1'b0; upd1_rdindex = '0; upd1_itag = '0;
        wb_valid = '0; wb_rdindex = '0; wb_itag = '0;
    endtask

    // Reference: tag-matched release, set beats release, port 1 beats port 0
    task automatic model_update();
        logic hit;
        if (arst_i || flush_i) begin
            m_busy = '0;
            m_id   = '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                hit = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    if (wb_valid[k] && wb_rdindex[k] == 5'(r) && wb_itag[k] == m_id[r]) hit = 1'b1;
                end
                if (upd1_write && upd1_rdindex == 5'(r)) begin
                    m_busy[r] = 1'b1; m_id[r] = upd1_itag;
                end else if (upd0_write && upd0_rdindex == 5'(r)) begin
                    m_busy[r] = 1'b1; m_id[r] = upd0_itag;
                end else if (m_busy[r] && hit) begin
                    m_busy[r] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk_i);
        #1;
        idle_inputs();
    endtask

    task automatic check_model(input string tag);
        int cnt;
        cnt = 0;
        for (int r = 0; r < 32; r++) cnt += int'(m_busy[r]);
        check({tag, "_busy"}, 256'(busy_flag), 256'(m_busy));
        check({tag, "_id"}, 256'(id_flag), 256'(m_id));
        check({tag, "_cnt"}, 256'(busy_cnt), 256'(cnt));
    endtask

    initial begin
        m_busy = '0;
        m_id   = '0;
        idle_inputs();
        arst_i = 1'b1;
        tick();
        arst_i = 1'b1;
        tick();

        // Reset state
        check("rst_busy", 256'(busy_flag), 256'd0);
        check("rst_id", 256'(id_flag), 256'd0);
        check("rst_cnt", 256'(busy_cnt), 256'd0);

        // Register 0 ignores set
        upd0_write = 1'b1; upd0_rdindex = 5'd0; upd0_itag = 8'd5;
        tick();
        check("r0_busy", 256'(busy_flag), 256'd0);
        check("r0_id", 256'(id_flag[0]), 256'd0);

        // Simple set then release
        upd0_write = 1'b1; upd0_rdindex = 5'd3; upd0_itag = 8'h12;
        tick();
        check("set3_busy", 256'(busy_flag[3]), 256'd1);
        check("set3_id", 256'(id_flag[3]), 256'h12);
        check("set3_cnt", 256'(busy_cnt), 256'd1);
        wb_valid = 2'b01; wb_rdindex[0] = 5'd3; wb_itag[0] = 8'h12;
        tick();
        check("rel3_busy", 256'(busy_flag), 256'd0);
        check("rel3_cnt", 256'(busy_cnt), 256'd0);

        // Re-claim: stale writeback must not release
        upd0_write = 1'b1; upd0_rdindex = 5'd7; upd0_itag = 8'd1;
        tick();
        upd0_write = 1'b1; upd0_rdindex = 5'd7; upd0_itag = 8'd2;
        tick();
        wb_valid = 2'b10; wb_rdindex[1] = 5'd7; wb_itag[1] = 8'd1;
        tick();
        check("stale_busy", 256'(busy_flag[7]), 256'd1);
        check("stale_id", 256'(id_flag[7]), 256'd2);
        wb_valid = 2'b10; wb_rdindex[1] = 5'd7; wb_itag[1] = 8'd2;
        tick();
        check("own_rel", 256'(busy_flag[7]), 256'd0);

        // Same-cycle double set, then set beats matching release
        upd0_write = 1'b1; upd0_rdindex = 5'd9; upd0_itag = 8'd4;
        upd1_write = 1'b1; upd1_rdindex = 5'd9; upd1_itag = 8'd5;
        tick();
        check("dual_id", 256'(id_flag[9]), 256'd5);
        wb_valid = 2'b01; wb_rdindex[0] = 5'd9; wb_itag[0] = 8'd5;
        upd0_write = 1'b1; upd0_rdindex = 5'd9; upd0_itag = 8'd6;
        tick();
        check("setrel_busy", 256'(busy_flag[9]), 256'd1);
        check("setrel_id", 256'(id_flag[9]), 256'd6);
        check("setrel_cnt", 256'(busy_cnt), 256'd1);

        // Fill every register, then flush with a concurrent set
        for (int r = 1; r < 32; r++) begin
            upd0_write = 1'b1; upd0_rdindex = 5'(r); upd0_itag = 8'(r + 8'h40);
            tick();
        end
        check("full_cnt", 256'(busy_cnt), 256'd31);
        check("full_busy", 256'(busy_flag), 256'hFFFF_FFFE);
        check("full_id31", 256'(id_flag[31]), 256'h5F);
        flush_i = 1'b1; upd0_write = 1'b1; upd0_rdindex = 5'd2; upd0_itag = 8'd3;
        tick();
        check("flush_busy", 256'(busy_flag), 256'd0);
        check("flush_id", 256'(id_flag), 256'd0);
        check("flush_cnt", 256'(busy_cnt), 256'd0);

        // Reset mid-traffic
        upd0_write = 1'b1; upd0_rdindex = 5'd4; upd0_itag = 8'd9;
        upd1_write = 1'b1; upd1_rdindex = 5'd5; upd1_itag = 8'd10;
        tick();
        arst_i = 1'b1; upd0_write = 1'b1; upd0_rdindex = 5'd6; upd0_itag = 8'd11;
        wb_valid = 2'b01; wb_rdindex[0] = 5'd4; wb_itag[0] = 8'd9;
        tick();
        check("arst_busy", 256'(busy_flag), 256'd0);
        check("arst_id", 256'(id_flag), 256'd0);
        check("arst_cnt", 256'(busy_cnt), 256'd0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            upd0_write    = ($urandom_range(0, 2) != 0);
            upd0_rdindex  = 5'($urandom_range(0, 11));
            upd0_itag     = 8'($urandom_range(0, 3));
            upd1_write    = ($urandom_range(0, 2) == 0);
            upd1_rdindex  = 5'($urandom_range(0, 11));
            upd1_itag     = 8'($urandom_range(0, 3));
            wb_valid      = 2'($urandom_range(0, 3));
            wb_rdindex[0] = 5'($urandom_range(0, 11));
            wb_rdindex[1] = 5'($urandom_range(0, 11));
            wb_itag[0]    = 8'($urandom_range(0, 3));
            wb_itag[1]    = 8'($urandom_range(0, 3));
            flush_i       = ($urandom_range(0, 60) == 0);
            arst_i        = ($urandom_range(0, 90) == 0);
            tick();
            check_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
